// File: rtl/dcache_wbuf_if.sv
// dcache_wbuf_if
//   Groups the DCache-side and system-bus-side signals of the posted-write
//   buffer into one bundle.
//   modport slave  : the buffer's view (dcache_wbuf)
//   modport master : the environment's view (DCache core + system arbiter)
//   DCache side : c_req, c_ack, c_addr, c_rdata, c_wdata, c_rd, c_wr, c_ready
//   Bus side    : bus_req, bus_ack, bus_addr, bus_rdata, bus_wdata,
//                 bus_rd, bus_wr, bus_ready
interface dcache_wbuf_if;
    logic        c_req;
    logic        c_ack;
    logic [31:0] c_addr;
    logic [31:0] c_rdata;
    logic [31:0] c_wdata;
    logic        c_rd;
    logic        c_wr;
    logic        c_ready;
    logic        bus_req;
    logic        bus_ack;
    logic [31:0] bus_addr;
    logic [31:0] bus_rdata;
    logic [31:0] bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic        bus_ready;

    modport slave (
        input  c_req, c_addr, c_wdata, c_rd, c_wr,
        input  bus_ack, bus_rdata, bus_ready,
        output c_ack, c_rdata, c_ready,
        output bus_req, bus_addr, bus_wdata, bus_rd, bus_wr
    );

    modport master (
        output c_req, c_addr, c_wdata, c_rd, c_wr,
        output bus_ack, bus_rdata, bus_ready,
        input  c_ack, c_rdata, c_ready,
        input  bus_req, bus_addr, bus_wdata, bus_rd, bus_wr
    );
endinterface

// File: rtl/dcache_wbuf.sv
// dcache_wbuf
//   Posted-write buffer between the DCache bus master port and the system
//   bus arbiter. Stores go into a DEPTH-entry FIFO and complete at once on
//   the core side; the FIFO drains in order. Line-fill reads pass through
//   combinationally once they are ordered against pending writes.
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   wb     dcache_wbuf_if.slave (DCache side + system bus side)
// Configuration macro:
//   WBUF_RAW_BYPASS_EN  when defined, reads that do not alias a buffered
//                       write (same 64-byte line) bypass the FIFO.
module dcache_wbuf #(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dcache_wbuf_if.slave  wb
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      r_state;
    logic        r_ack;

    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic [DEPTH-1:0] r_valid;
    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];

    logic [AW-1:0] w_wi;
    logic [AW-1:0] w_ri;
    logic          w_full;
    logic          w_empty;
    logic          w_head_vld;
    logic          w_read_go;
    logic          w_push;
    logic          w_pop;
    logic          w_c_ready;
    logic          w_bus_req;
    logic          w_bus_rd;
    logic          w_bus_wr;
    logic [31:0]   w_bus_addr;
    logic [31:0]   w_bus_wdata;

    assign w_wi    = r_wp[AW-1:0];
    assign w_ri    = r_rp[AW-1:0];
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (w_wi == w_ri);
    assign w_head_vld = r_valid[w_ri];

`ifdef WBUF_RAW_BYPASS_EN
    logic w_hit;

    // Line-granular alias check against every buffered entry.
    always_comb begin
        w_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i][31:6] == wb.c_addr[31:6]))
                w_hit = 1'b1;
        end
    end

    assign w_read_go = r_ack & wb.c_rd & ~w_hit;
`else
    assign w_read_go = r_ack & wb.c_rd & w_empty;
`endif

    // Both strobes high is illegal: the read side wins and nothing is pushed.
    // A same-cycle pop never frees the slot for this push (full is registered state).
    assign w_push = r_ack & wb.c_wr & ~wb.c_rd & ~w_full;

    always_comb begin
        w_c_ready   = 1'b0;
        w_bus_req   = 1'b0;
        w_bus_rd    = 1'b0;
        w_bus_wr    = 1'b0;
        w_bus_addr  = '0;
        w_bus_wdata = '0;
        w_pop       = 1'b0;
        if (w_read_go) begin
            w_bus_req  = 1'b1;
            w_bus_rd   = wb.bus_ack;
            w_bus_addr = wb.c_addr;
            w_c_ready  = wb.bus_ack & wb.bus_ready;
        end else begin
            w_c_ready = w_push;
            if (w_head_vld) begin
                w_bus_req   = 1'b1;
                w_bus_wr    = wb.bus_ack;
                w_bus_addr  = r_addr[w_ri];
                w_bus_wdata = r_data[w_ri];
                w_pop       = wb.bus_ack & wb.bus_ready;
            end
        end
    end

    assign wb.c_ack     = r_ack;
    assign wb.c_rdata   = wb.bus_rdata;
    assign wb.c_ready   = w_c_ready;
    assign wb.bus_req   = w_bus_req;
    assign wb.bus_rd    = w_bus_rd;
    assign wb.bus_wr    = w_bus_wr;
    assign wb.bus_addr  = w_bus_addr;
    assign wb.bus_wdata = w_bus_wdata;

    // Grant FSM; ack is a register so it never depends on the strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (wb.c_req) begin
                    r_state <= GRANT;
                    r_ack   <= 1'b1;
                end
                GRANT: if (!wb.c_req) begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_wp          <= r_wp + {{AW{1'b0}}, 1'b1};
                r_valid[w_wi] <= 1'b1;
            end
            if (w_pop) begin
                r_rp          <= r_rp + {{AW{1'b0}}, 1'b1};
                r_valid[w_ri] <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset; entries are qualified by r_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[w_wi] <= wb.c_addr;
            r_data[w_wi] <= wb.c_wdata;
        end
    end
endmodule

// File: tb/tb_dcache_wbuf.sv
// tb_dcache_wbuf
//   Directed self-checking bench for dcache_wbuf (DEPTH = 4). Inputs change
//   on the falling edge; outputs are sampled 1 time unit later.
module tb_dcache_wbuf;
    logic clk;
    logic rst_n;
    int   n_asserts;
    int   n_fail;

    dcache_wbuf_if u_if ();

    dcache_wbuf #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] rd_val;
        n_asserts = 0;
        n_fail    = 0;

        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            u_if.c_req     = 1'($urandom_range(0, 1));
            u_if.c_rd      = 1'($urandom_range(0, 1));
            u_if.c_wr      = 1'($urandom_range(0, 1));
            u_if.c_addr    = $urandom;
            u_if.c_wdata   = $urandom;
            u_if.bus_ack   = 1'($urandom_range(0, 1));
            u_if.bus_ready = 1'($urandom_range(0, 1));
            rd_val         = $urandom;
            u_if.bus_rdata = rd_val;
            #1;
            chk("rst_c_ack",     32'(u_if.c_ack),   32'd0);
            chk("rst_c_ready",   32'(u_if.c_ready), 32'd0);
            chk("rst_bus_req",   32'(u_if.bus_req), 32'd0);
            chk("rst_bus_rd",    32'(u_if.bus_rd),  32'd0);
            chk("rst_bus_wr",    32'(u_if.bus_wr),  32'd0);
            chk("rst_bus_addr",  u_if.bus_addr,     32'd0);
            chk("rst_bus_wdata", u_if.bus_wdata,    32'd0);
            chk("rst_c_rdata",   u_if.c_rdata,      rd_val);
        end

        @(negedge clk);
        u_if.c_req = 0; u_if.c_rd = 0; u_if.c_wr = 0;
        u_if.c_addr = 0; u_if.c_wdata = 0;
        u_if.bus_ack = 0; u_if.bus_ready = 0; u_if.bus_rdata = 0;
        rst_n = 1'b1;
        #1 chk("post_rst_ack", 32'(u_if.c_ack), 32'd0);

        // Grant latency: one clock from c_req
        @(negedge clk);
        u_if.c_req = 1;
        #1 chk("grant_same_cycle", 32'(u_if.c_ack), 32'd0);
        @(negedge clk);
        #1 chk("grant_next_cycle", 32'(u_if.c_ack), 32'd1);

        // Single write
        @(negedge clk);
        u_if.bus_ack = 1; u_if.bus_ready = 1;
        u_if.c_wr = 1; u_if.c_addr = 32'h0000_1004; u_if.c_wdata = 32'hDEAD_BEEF;
        #1;
        chk("sw_c_ready", 32'(u_if.c_ready), 32'd1);
        chk("sw_bus_wr_same", 32'(u_if.bus_wr), 32'd0);
        @(negedge clk);
        u_if.c_wr = 0; u_if.c_addr = 0; u_if.c_wdata = 0;
        #1;
        chk("sw_bus_wr",    32'(u_if.bus_wr), 32'd1);
        chk("sw_bus_addr",  u_if.bus_addr,    32'h0000_1004);
        chk("sw_bus_wdata", u_if.bus_wdata,   32'hDEAD_BEEF);
        @(negedge clk);
        #1 chk("sw_drained", 32'(u_if.bus_req), 32'd0);

        // Backpressure: five writes against a stalled bus
        @(negedge clk);
        u_if.bus_ack = 0; u_if.bus_ready = 1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            u_if.c_wr = 1;
            u_if.c_addr  = 32'h0000_0100 + 32'(4 * k);
            u_if.c_wdata = 32'hA000_0000 + 32'(k);
            #1;
            chk($sformatf("bp_ready_%0d", k), 32'(u_if.c_ready), (k < 4) ? 32'd1 : 32'd0);
            chk($sformatf("bp_nowr_%0d", k), 32'(u_if.bus_wr), 32'd0);
        end
        @(negedge clk);
        u_if.bus_ack = 1;
        #1;
        chk("bp_pop_noslot", 32'(u_if.c_ready), 32'd0);
        chk("bp_addr0", u_if.bus_addr, 32'h0000_0100);
        chk("bp_data0", u_if.bus_wdata, 32'hA000_0000);
        @(negedge clk);
        #1;
        chk("bp_fifth_ready", 32'(u_if.c_ready), 32'd1);
        chk("bp_addr1", u_if.bus_addr, 32'h0000_0104);
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            u_if.c_wr = 0;
            #1;
            chk($sformatf("bp_wr_%0d", k), 32'(u_if.bus_wr), 32'd1);
            chk($sformatf("bp_addr_%0d", k), u_if.bus_addr, 32'h0000_0100 + 32'(4 * k));
            chk($sformatf("bp_data_%0d", k), u_if.bus_wdata, 32'hA000_0000 + 32'(k));
        end
        @(negedge clk);
        #1 chk("bp_empty", 32'(u_if.bus_req), 32'd0);

`ifdef WBUF_RAW_BYPASS_EN
        // Bypass: non-aliasing read goes straight out, aliasing read waits
        @(negedge clk);
        u_if.bus_ack = 0;
        u_if.c_wr = 1; u_if.c_addr = 32'h0000_1000; u_if.c_wdata = 32'h1111_2222;
        #1 chk("byp_push", 32'(u_if.c_ready), 32'd1);
        @(negedge clk);
        u_if.c_wr = 0; u_if.c_rd = 1; u_if.c_addr = 32'h0000_2000;
        u_if.bus_ack = 1; u_if.bus_ready = 1; u_if.bus_rdata = 32'h5555_AAAA;
        #1;
        chk("byp_rd",     32'(u_if.bus_rd), 32'd1);
        chk("byp_nowr",   32'(u_if.bus_wr), 32'd0);
        chk("byp_addr",   u_if.bus_addr,    32'h0000_2000);
        chk("byp_ready",  32'(u_if.c_ready), 32'd1);
        chk("byp_rdata",  u_if.c_rdata,     32'h5555_AAAA);
        @(negedge clk);
        u_if.c_addr = 32'h0000_1020;
        #1;
        chk("alias_rd_wait", 32'(u_if.bus_rd), 32'd0);
        chk("alias_wr",      32'(u_if.bus_wr), 32'd1);
        chk("alias_wr_addr", u_if.bus_addr,    32'h0000_1000);
        chk("alias_ready",   32'(u_if.c_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("alias_rd_go",   32'(u_if.bus_rd), 32'd1);
        chk("alias_rd_addr", u_if.bus_addr,    32'h0000_1020);
        @(negedge clk);
        u_if.c_rd = 0; u_if.c_addr = 0;
`else
        // Read ordering: read waits for both pending writes to drain
        @(negedge clk);
        u_if.bus_ack = 0;
        u_if.c_wr = 1; u_if.c_addr = 32'h0000_3000; u_if.c_wdata = 32'h3333_0000;
        @(negedge clk);
        u_if.c_addr = 32'h0000_3004; u_if.c_wdata = 32'h3333_0004;
        @(negedge clk);
        u_if.c_wr = 0; u_if.c_rd = 1; u_if.c_addr = 32'h0000_2000;
        #1;
        chk("ro_rd_blocked", 32'(u_if.bus_rd),  32'd0);
        chk("ro_req",        32'(u_if.bus_req), 32'd1);
        chk("ro_ready0",     32'(u_if.c_ready), 32'd0);
        @(negedge clk);
        u_if.bus_ack = 1; u_if.bus_ready = 1;
        #1;
        chk("ro_rd_wait1", 32'(u_if.bus_rd), 32'd0);
        chk("ro_wr1_addr", u_if.bus_addr,    32'h0000_3000);
        @(negedge clk);
        #1;
        chk("ro_rd_wait2", 32'(u_if.bus_rd), 32'd0);
        chk("ro_wr2_addr", u_if.bus_addr,    32'h0000_3004);
        chk("ro_wr2_data", u_if.bus_wdata,   32'h3333_0004);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            u_if.c_addr = 32'h0000_2000 + 32'(4 * i);
            rd_val = 32'hF000_0000 + 32'(i * 17);
            u_if.bus_rdata = rd_val;
            #1;
            chk($sformatf("fill_rd_%0d", i),    32'(u_if.bus_rd),  32'd1);
            chk($sformatf("fill_addr_%0d", i),  u_if.bus_addr,     32'h0000_2000 + 32'(4 * i));
            chk($sformatf("fill_ready_%0d", i), 32'(u_if.c_ready), 32'd1);
            chk($sformatf("fill_data_%0d", i),  u_if.c_rdata,      rd_val);
            chk($sformatf("fill_ack_%0d", i),   32'(u_if.c_ack),   32'd1);
        end
        @(negedge clk);
        u_if.c_rd = 0; u_if.c_addr = 0;
`endif

        // Strobe violation: read wins, nothing pushed
        @(negedge clk);
        u_if.bus_ack = 1; u_if.bus_ready = 1;
        u_if.c_rd = 1; u_if.c_wr = 1;
        u_if.c_addr = 32'h0000_4000; u_if.c_wdata = 32'h4444_4444;
        #1;
        chk("sv_bus_rd", 32'(u_if.bus_rd),  32'd1);
        chk("sv_ready",  32'(u_if.c_ready), 32'd1);
        @(negedge clk);
        u_if.c_rd = 0; u_if.c_wr = 0;
        #1 chk("sv_no_push", 32'(u_if.bus_req), 32'd0);

        // Grant drop and re-grant
        @(negedge clk);
        u_if.c_req = 0;
        #1 chk("drop_same", 32'(u_if.c_ack), 32'd1);
        @(negedge clk);
        #1 chk("drop_next", 32'(u_if.c_ack), 32'd0);
        @(negedge clk);
        u_if.c_req = 1;
        @(negedge clk);
        #1 chk("regrant", 32'(u_if.c_ack), 32'd1);

        // Reset mid-drain with three entries pending
        u_if.bus_ack = 0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            u_if.c_wr = 1;
            u_if.c_addr  = 32'h0000_5000 + 32'(4 * k);
            u_if.c_wdata = 32'h5000_0000 + 32'(k);
        end
        @(negedge clk);
        u_if.c_wr = 0; u_if.bus_ack = 1;
        #1 chk("md_draining", 32'(u_if.bus_wr), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("md_rst_wr",  32'(u_if.bus_wr),  32'd0);
        chk("md_rst_req", 32'(u_if.bus_req), 32'd0);
        chk("md_rst_ack", 32'(u_if.c_ack),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("md_rel_req", 32'(u_if.bus_req), 32'd0);
        chk("md_rel_ack", 32'(u_if.c_ack),   32'd0);
        @(negedge clk);
        #1;
        chk("md_empty", 32'(u_if.bus_wr), 32'd0);
        chk("md_ack",   32'(u_if.c_ack),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
